// File: rtl/eth_40gb_link_ctrl.sv
// 40GbE QSFP link bring-up sequencer: walks PLL, PHY reset, CDR, block and
// alignment lock in order, retries on timeout and qualifies the link before link_up.
module eth_40gb_link_ctrl #(
  parameter int unsigned LANES          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RESET_CYCLES   = 64,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES    = 8
) (
  input  logic             core_clk,
  input  logic             core_resetn,
  input  logic             enable,
  input  logic             fault_clear,
  input  logic             core_pll_locked,
  input  logic             tx_pll_locked,
  input  logic [LANES-1:0] tx_ready,
  input  logic [LANES-1:0] rx_ready,
  input  logic [LANES-1:0] rx_is_lockedtodata,
  input  logic [LANES-1:0] rx_blk_lock,
  input  logic             rx_am_lock,
  output logic             phy_reset_req,
  output logic             qsfp_rstn,
  output logic             link_up,
  output logic             fault,
  output logic [3:0]       state,
  output logic [3:0]       retry_cnt,
  output logic [15:0]      drop_cnt
);

  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StWaitPll   = 4'd1,
    StPhyRst    = 4'd2,
    StWaitTx    = 4'd3,
    StWaitRx    = 4'd4,
    StWaitBlk   = 4'd5,
    StWaitAlign = 4'd6,
    StStable    = 4'd7,
    StUp        = 4'd8,
    StFault     = 4'd9
  } state_e;

  localparam int unsigned SyncW = 3 + 4 * LANES;

  localparam int unsigned TimerMax0 = (TIMEOUT_CYCLES > STABLE_CYCLES) ? TIMEOUT_CYCLES
                                                                       : STABLE_CYCLES;
  localparam int unsigned TimerMax  = (TimerMax0 > RESET_CYCLES) ? TimerMax0 : RESET_CYCLES;
  localparam int unsigned TimerW    = $clog2(TimerMax + 1);

  localparam logic [TimerW-1:0] TimerLast   = TimerW'(TimerMax);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] ResetLast   = TimerW'(RESET_CYCLES - 1);
  localparam logic [TimerW-1:0] StableLast  = TimerW'(STABLE_CYCLES - 1);
  localparam logic [3:0]        RetryLast   = 4'(MAX_RETRIES - 1);
  localparam logic [3:0]        RetryFault  = 4'(MAX_RETRIES);

  // Two-flop synchronizers for every asynchronous status input.
  logic [SyncW-1:0] sync_raw, sync_q1, sync_q2;

  assign sync_raw = {core_pll_locked, tx_pll_locked, tx_ready, rx_ready,
                     rx_is_lockedtodata, rx_blk_lock, rx_am_lock};

  always_ff @(posedge core_clk or negedge core_resetn) begin
    if (!core_resetn) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= sync_raw;
      sync_q2 <= sync_q1;
    end
  end

  logic             core_pll_s, tx_pll_s, am_s;
  logic [LANES-1:0] tx_ready_s, rx_ready_s, cdr_s, blk_s;

  assign {core_pll_s, tx_pll_s, tx_ready_s, rx_ready_s, cdr_s, blk_s, am_s} = sync_q2;

  logic pll_ok, tx_ok, rx_ok, blk_ok, all_ok;

  assign pll_ok = core_pll_s & tx_pll_s;
  assign tx_ok  = &tx_ready_s;
  assign rx_ok  = (&rx_ready_s) & (&cdr_s);
  assign blk_ok = &blk_s;
  assign all_ok = pll_ok & tx_ok & rx_ok & blk_ok & am_s;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q;
  logic [3:0]        retry_q, retry_d;
  logic [15:0]       drop_q, drop_d, drop_inc;
  logic              timed_out, attempt_fail;

  assign timed_out = (timer_q == TimeoutLast);
  assign drop_inc  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    drop_d       = drop_q;
    attempt_fail = 1'b0;

    if (!enable) begin
      state_d = StIdle;
    end else if (!pll_ok && (state_q != StIdle) && (state_q != StFault)) begin
      // PLL loss restarts from the PLL wait without charging a retry.
      state_d = StWaitPll;
      if (state_q == StUp) drop_d = drop_inc;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StWaitPll;
        StWaitPll: state_d = StPhyRst;
        StPhyRst: begin
          if (timer_q == ResetLast) state_d = StWaitTx;
        end
        StWaitTx: begin
          if (timed_out)  attempt_fail = 1'b1;
          else if (tx_ok) state_d = StWaitRx;
        end
        StWaitRx: begin
          if (timed_out)  attempt_fail = 1'b1;
          else if (rx_ok) state_d = StWaitBlk;
        end
        StWaitBlk: begin
          if (timed_out)   attempt_fail = 1'b1;
          else if (blk_ok) state_d = StWaitAlign;
        end
        StWaitAlign: begin
          if (timed_out) attempt_fail = 1'b1;
          else if (am_s) state_d = StStable;
        end
        StStable: begin
          if (!all_ok)                   attempt_fail = 1'b1;
          else if (timer_q == StableLast) state_d = StUp;
        end
        StUp: begin
          if (!all_ok) begin
            state_d = StPhyRst;
            drop_d  = drop_inc;
          end
        end
        StFault: begin
          if (fault_clear) begin
            state_d = StWaitPll;
            retry_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (attempt_fail) begin
      if (retry_q >= RetryLast) begin
        state_d = StFault;
        retry_d = RetryFault;
      end else begin
        state_d = StPhyRst;
        retry_d = retry_q + 4'd1;
      end
    end

    if ((state_d == StUp) && (state_q != StUp)) retry_d = '0;
  end

  always_ff @(posedge core_clk or negedge core_resetn) begin
    if (!core_resetn) begin
      state_q <= StIdle;
      timer_q <= '0;
      retry_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      drop_q  <= drop_d;
      // Shared dwell timer restarts on every state change and saturates otherwise.
      if (state_d != state_q) timer_q <= '0;
      else if (timer_q != TimerLast) timer_q <= timer_q + TimerW'(1);
    end
  end

  always_comb begin
    phy_reset_req = 1'b0;
    qsfp_rstn     = 1'b1;
    link_up       = 1'b0;
    fault         = 1'b0;
    unique case (state_q)
      StIdle: begin
        phy_reset_req = 1'b1;
        qsfp_rstn     = 1'b0;
      end
      StWaitPll, StPhyRst: phy_reset_req = 1'b1;
      StUp:                link_up       = 1'b1;
      StFault:             fault         = 1'b1;
      default: ;
    endcase
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_eth_40gb_link_ctrl.sv
// Bench for eth_40gb_link_ctrl: directed vector table, reset checks and random
// status disturbances, all compared against a cycle-level model of the bring-up rules.
module tb_eth_40gb_link_ctrl;

  localparam int Lanes  = 4;
  localparam int ToCyc  = 100;
  localparam int RstCyc = 4;
  localparam int StbCyc = 8;
  localparam int MaxRet = 2;

  localparam int SIdle = 0, SWaitPll = 1, SPhyRst = 2, SWaitTx = 3, SWaitRx = 4;
  localparam int SWaitBlk = 5, SWaitAlign = 6, SStable = 7, SUp = 8, SFault = 9;

  logic core_clk = 1'b0;
  logic core_resetn, enable, fault_clear;
  // {core_pll, tx_pll, tx_ready[3:0], rx_ready[3:0], cdr[3:0], blk[3:0], am}
  logic [18:0] st;
  logic        phy_reset_req, qsfp_rstn, link_up, fault;
  logic [3:0]  state, retry_cnt;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  eth_40gb_link_ctrl #(
    .LANES          (Lanes),
    .TIMEOUT_CYCLES (ToCyc),
    .RESET_CYCLES   (RstCyc),
    .STABLE_CYCLES  (StbCyc),
    .MAX_RETRIES    (MaxRet)
  ) dut (
    .core_clk           (core_clk),
    .core_resetn        (core_resetn),
    .enable             (enable),
    .fault_clear        (fault_clear),
    .core_pll_locked    (st[18]),
    .tx_pll_locked      (st[17]),
    .tx_ready           (st[16:13]),
    .rx_ready           (st[12:9]),
    .rx_is_lockedtodata (st[8:5]),
    .rx_blk_lock        (st[4:1]),
    .rx_am_lock         (st[0]),
    .phy_reset_req      (phy_reset_req),
    .qsfp_rstn          (qsfp_rstn),
    .link_up            (link_up),
    .fault              (fault),
    .state              (state),
    .retry_cnt          (retry_cnt),
    .drop_cnt           (drop_cnt)
  );

  always #5 core_clk = ~core_clk;

  // Reference model: phase number, cycles spent in it, counters, and the last two
  // sampled status words (what the design can see is always two edges old).
  int          m_state, m_dwell, m_retry, m_drop;
  logic [18:0] m_seen [2];

  function automatic void model_reset();
    m_state   = SIdle;
    m_dwell   = 0;
    m_retry   = 0;
    m_drop    = 0;
    m_seen[0] = '0;
    m_seen[1] = '0;
  endfunction

  function automatic void model_step(input logic en, input logic fc, input logic [18:0] s);
    logic [18:0] c;
    logic        pll, all_ok;
    logic        ok [3:6];
    int          nxt;
    logic        failed;
    c      = m_seen[1];
    pll    = c[18] & c[17];
    ok[3]  = &c[16:13];
    ok[4]  = (&c[12:9]) & (&c[8:5]);
    ok[5]  = &c[4:1];
    ok[6]  = c[0];
    all_ok = pll & ok[3] & ok[4] & ok[5] & ok[6];
    nxt    = m_state;
    failed = 1'b0;
    if (!en) begin
      nxt = SIdle;
    end else if (!pll && m_state != SIdle && m_state != SFault) begin
      nxt = SWaitPll;
      if (m_state == SUp && m_drop < 65535) m_drop++;
    end else if (m_state == SIdle || m_state == SWaitPll) begin
      nxt = m_state + 1;
    end else if (m_state == SPhyRst) begin
      if (m_dwell + 1 == RstCyc) nxt = SWaitTx;
    end else if (m_state >= SWaitTx && m_state <= SWaitAlign) begin
      if (m_dwell + 1 == ToCyc) failed = 1'b1;
      else if (ok[m_state])     nxt = m_state + 1;
    end else if (m_state == SStable) begin
      if (!all_ok)                    failed = 1'b1;
      else if (m_dwell + 1 == StbCyc) nxt = SUp;
    end else if (m_state == SUp) begin
      if (!all_ok) begin
        nxt = SPhyRst;
        if (m_drop < 65535) m_drop++;
      end
    end else if (m_state == SFault && fc) begin
      nxt     = SWaitPll;
      m_retry = 0;
    end
    if (failed) begin
      if (m_retry + 1 >= MaxRet) begin
        nxt     = SFault;
        m_retry = MaxRet;
      end else begin
        nxt     = SPhyRst;
        m_retry = m_retry + 1;
      end
    end
    if (nxt == SUp && m_state != SUp) m_retry = 0;
    m_dwell   = (nxt != m_state) ? 0 : m_dwell + 1;
    m_state   = nxt;
    m_seen[1] = m_seen[0];
    m_seen[0] = s;
  endfunction

  task automatic check_pt(input string name, input int es, input int er, input int ed);
    logic want_prr, want_qs, want_up, want_ft;
    want_prr = (es <= SPhyRst);
    want_qs  = (es != SIdle);
    want_up  = (es == SUp);
    want_ft  = (es == SFault);
    n_cmp++;
    if (state !== 4'(es) || retry_cnt !== 4'(er) || drop_cnt !== 16'(ed) ||
        phy_reset_req !== want_prr || qsfp_rstn !== want_qs || link_up !== want_up ||
        fault !== want_ft) begin
      n_bad++;
      $display("FAIL %s t=%0t got state=%0d retry=%0d drop=%0d prr=%b qsfp=%b up=%b fault=%b want state=%0d retry=%0d drop=%0d prr=%b qsfp=%b up=%b fault=%b",
               name, $time, state, retry_cnt, drop_cnt, phy_reset_req, qsfp_rstn,
               link_up, fault, es, er, ed, want_prr, want_qs, want_up, want_ft);
    end
  endtask

  task automatic tick();
    model_step(enable, fault_clear, st);
    @(posedge core_clk);
    #1;
    check_pt("model", m_state, m_retry, m_drop);
  endtask

  typedef struct {
    logic        en;
    logic        fc;
    logic [18:0] st;
    int          cyc;
    int          es;
    int          er;
    int          ed;
  } row_t;

  row_t rows [35];

  task automatic set_row(input int i, input logic en, input logic fc, input logic tpll,
                         input logic rxr2, input logic [3:0] blk, input logic am,
                         input int cyc, input int es, input int er, input int ed);
    rows[i].en  = en;
    rows[i].fc  = fc;
    rows[i].st  = {1'b1, tpll, 4'hF, 1'b1, rxr2, 2'b11, 4'hF, blk, am};
    rows[i].cyc = cyc;
    rows[i].es  = es;
    rows[i].er  = er;
    rows[i].ed  = ed;
  endtask

  int          hold_cnt, hold_bit;
  logic [18:0] s;

  initial begin
    //          i  en fc tp r2 blk    am cyc st er dr
    set_row( 0, 0, 0, 1, 1, 4'hF, 1,   4, 0, 0, 0);  // idle while disabled
    set_row( 1, 1, 0, 1, 1, 4'hF, 1,   2, 2, 0, 0);  // clean bring-up
    set_row( 2, 1, 0, 1, 1, 4'hF, 1,   4, 3, 0, 0);  // PHY_RST held exactly 4
    set_row( 3, 1, 0, 1, 1, 4'hF, 1,   4, 7, 0, 0);
    set_row( 4, 1, 0, 1, 1, 4'hF, 1,   7, 7, 0, 0);
    set_row( 5, 1, 0, 1, 1, 4'hF, 1,   1, 8, 0, 0);  // UP 18 cycles after enable
    set_row( 6, 1, 0, 1, 0, 4'hF, 1,   2, 8, 0, 0);  // rx_ready[2] drop, in sync
    set_row( 7, 1, 0, 1, 0, 4'hF, 1,   1, 2, 0, 1);  // seen on 3rd edge
    set_row( 8, 1, 0, 1, 0, 4'hF, 1,   5, 4, 0, 1);
    set_row( 9, 1, 0, 1, 1, 4'h7, 1,   3, 5, 0, 1);  // block lock stuck on lane 3
    set_row(10, 1, 0, 1, 1, 4'h7, 1,  99, 5, 0, 1);
    set_row(11, 1, 0, 1, 1, 4'h7, 1,   1, 2, 1, 1);  // first timeout
    set_row(12, 1, 0, 1, 1, 4'h7, 1,   6, 5, 1, 1);
    set_row(13, 1, 0, 1, 1, 4'h7, 1, 100, 9, 2, 1);  // second timeout -> FAULT
    set_row(14, 1, 1, 1, 1, 4'h7, 1,   1, 1, 0, 1);  // fault_clear
    set_row(15, 1, 0, 1, 1, 4'hF, 1,   1, 2, 0, 1);
    set_row(16, 1, 0, 1, 1, 4'hF, 1,   8, 7, 0, 1);
    set_row(17, 1, 0, 1, 1, 4'hF, 1,   3, 7, 0, 1);
    set_row(18, 1, 0, 1, 1, 4'hF, 0,   1, 7, 0, 1);  // one-cycle am glitch
    set_row(19, 1, 0, 1, 1, 4'hF, 1,   1, 7, 0, 1);
    set_row(20, 1, 0, 1, 1, 4'hF, 1,   1, 2, 1, 1);
    set_row(21, 1, 0, 1, 0, 4'hF, 1,   5, 4, 1, 1);  // park in WAIT_RX
    set_row(22, 1, 0, 1, 0, 4'hF, 1,  97, 4, 1, 1);
    set_row(23, 1, 0, 0, 0, 4'hF, 1,   1, 4, 1, 1);  // PLL loss lands on timeout edge
    set_row(24, 1, 0, 0, 0, 4'hF, 1,   1, 4, 1, 1);
    set_row(25, 1, 0, 0, 0, 4'hF, 1,   1, 1, 1, 1);
    set_row(26, 1, 0, 1, 1, 4'hF, 1,   2, 1, 1, 1);
    set_row(27, 1, 0, 1, 1, 4'hF, 1,   1, 2, 1, 1);
    set_row(28, 1, 0, 1, 1, 4'hF, 1,  15, 7, 1, 1);
    set_row(29, 1, 0, 1, 1, 4'hF, 1,   1, 8, 0, 1);
    set_row(30, 1, 0, 0, 1, 4'hF, 1,   2, 8, 0, 1);  // PLL loss in UP
    set_row(31, 1, 0, 0, 1, 4'hF, 1,   1, 1, 0, 2);
    set_row(32, 1, 0, 1, 1, 4'hF, 1,  18, 7, 0, 2);
    set_row(33, 1, 0, 1, 1, 4'hF, 1,   1, 8, 0, 2);
    set_row(34, 0, 0, 1, 1, 4'hF, 1,   1, 0, 0, 2);  // disable from UP keeps drop_cnt

    core_resetn = 1'b0;
    enable      = 1'b0;
    fault_clear = 1'b0;
    st          = '1;
    model_reset();
    #12;
    check_pt("reset_values", SIdle, 0, 0);
    @(posedge core_clk);
    #1;
    core_resetn = 1'b1;

    foreach (rows[i]) begin
      enable      = rows[i].en;
      fault_clear = rows[i].fc;
      st          = rows[i].st;
      repeat (rows[i].cyc) tick();
      check_pt($sformatf("row%0d", i), rows[i].es, rows[i].er, rows[i].ed);
    end

    // Asynchronous reset in the middle of STABLE.
    enable = 1'b1;
    st     = '1;
    repeat (14) tick();
    check_pt("mid_stable", SStable, 0, 2);
    #3;
    core_resetn = 1'b0;
    #1;
    check_pt("async_reset", SIdle, 0, 0);
    repeat (2) @(posedge core_clk);
    #1;
    core_resetn = 1'b1;
    model_reset();

    // Random disturbances: short single-bit drops plus occasional long holds
    // that are long enough to trip the wait timeouts.
    hold_cnt = 0;
    hold_bit = 0;
    for (int i = 0; i < 4000; i++) begin
      enable      = ($urandom_range(0, 299) != 0);
      fault_clear = ($urandom_range(0, 39) == 0);
      if (hold_cnt > 0) begin
        hold_cnt--;
      end else if ($urandom_range(0, 199) == 0) begin
        hold_cnt = $urandom_range(50, 250);
        hold_bit = $urandom_range(0, 18);
      end
      s = '1;
      if (hold_cnt > 0) s[hold_bit] = 1'b0;
      if ($urandom_range(0, 59) == 0) s[$urandom_range(0, 18)] = 1'b0;
      st = s;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
